// File: rtl/cheat_pkg.sv
// Shared types and code-word field offsets for the cheat loader.
package cheat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_STROBE_HI,
        ST_STROBE_LO,
        ST_CLEAR
    } state_t;

    typedef logic [1:0] widx_t;

    localparam int WORD_W     = 32;
    localparam int CODE_W     = 129;
    localparam int STROBE_BIT = 128;
    localparam int FLAGS_LSB  = 96;
    localparam int ADDR_LSB   = 64;
    localparam int CMP_LSB    = 32;
    localparam int REPL_LSB   = 0;

endpackage

// File: rtl/cheat_word_swap.sv
// Optional byte reversal of an incoming host word; pure combinational, zero latency.
// Reverses bytes when CHEAT_LOADER_BYTESWAP_EN is defined, otherwise passes through.
module cheat_word_swap
    import cheat_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);

`ifdef CHEAT_LOADER_BYTESWAP_EN
    assign word_o = {word_i[7:0], word_i[15:8], word_i[23:16], word_i[31:24]};
`else
    assign word_o = word_i;
`endif

endmodule

// File: rtl/cheat_loader.sv
// Assembles 4-word cheat codes and strobes them into the matcher; clear flushes the table.
// Build option CHEAT_LOADER_BYTESWAP_EN byte-reverses each accepted word (see cheat_word_swap).
module cheat_loader
    import cheat_pkg::*;
#(
    parameter int MAX_CODES   = 32,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_req,
    input  logic                           wr_valid,
    input  logic [31:0]                    wr_data,
    output logic                           wr_ready,
    output logic [128:0]                   code,
    output logic                           codes_reset,
    output logic [$clog2(MAX_CODES+1)-1:0] loaded_count,
    output logic                           overflow,
    output logic                           busy
);

    localparam int                CNT_W     = $clog2(MAX_CODES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CODES);
    localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    widx_t               idx_q, idx_d;
    logic [3:0]          hold_q, hold_d;
    logic [95:0]         stage_q, stage_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                crst_q, crst_d;
    logic                rdy_q, rdy_d;
    logic [WORD_W-1:0]   word;
    logic                xfer;

    cheat_word_swap u_swap (
        .word_i (wr_data),
        .word_o (word)
    );

    assign xfer = wr_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        stage_d = stage_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (xfer) begin
                    idx_d = widx_t'(idx_q + 2'd1);
                    case (idx_q)
                        2'd0: stage_d[FLAGS_LSB-WORD_W +: WORD_W] = word;
                        2'd1: stage_d[ADDR_LSB-WORD_W +: WORD_W]  = word;
                        2'd2: stage_d[CMP_LSB-WORD_W +: WORD_W]   = word;
                        default: ;
                    endcase
                    if (idx_q != 2'd3) begin
                        state_d = ST_COLLECT;
                    end else if (cnt_q < CNT_MAX) begin
                        // Replace word lands straight in the output; the other three come from staging.
                        code_d[STROBE_BIT]            = 1'b1;
                        code_d[FLAGS_LSB +: WORD_W]   = stage_q[FLAGS_LSB-WORD_W +: WORD_W];
                        code_d[ADDR_LSB +: WORD_W]    = stage_q[ADDR_LSB-WORD_W +: WORD_W];
                        code_d[CMP_LSB +: WORD_W]     = stage_q[CMP_LSB-WORD_W +: WORD_W];
                        code_d[REPL_LSB +: WORD_W]    = word;
                        cnt_d   = cnt_q + 1'b1;
                        hold_d  = 4'd0;
                        state_d = ST_STROBE_HI;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STROBE_HI: begin
                if (hold_q == HOLD_LAST) begin
                    code_d[STROBE_BIT] = 1'b0;
                    hold_d  = 4'd0;
                    state_d = ST_STROBE_LO;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_STROBE_LO, ST_CLEAR: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear wins over any same-cycle word; a repeat clear during CLEAR must not restart the hold.
        if (clear_req && (state_q != ST_CLEAR)) begin
            state_d = ST_CLEAR;
            hold_d  = 4'd0;
            idx_d   = 2'd0;
            stage_d = stage_q;
            code_d  = {1'b0, code_q[STROBE_BIT-1:0]};
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end

        crst_d = (state_d == ST_CLEAR);
        rdy_d  = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            hold_q  <= 4'd0;
            stage_q <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            crst_q  <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            stage_q <= stage_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            crst_q  <= crst_d;
            rdy_q   <= rdy_d;
        end
    end

    assign wr_ready     = rdy_q;
    assign code         = code_q;
    assign codes_reset  = crst_q;
    assign loaded_count = cnt_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
